// File: rtl/clock_counter_arbiter.sv
// Round-robin arbiter that hands one shared cycle counter to N_REQ requesters,
// forwarding the owner's clear/start/stop ops and capturing the count at release.
module clock_counter_arbiter #(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     op_valid,
  input  logic [2*N_REQ-1:0]   op,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 cc_enable,
  output logic [31:0]          cc_command,
  input  logic [CNT_W-1:0]     cc_count,
  output logic [CNT_W-1:0]     result,
  output logic                 result_valid,
  output logic [N_REQ-1:0]     result_owner,
  output logic                 timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_STOP    = 2'd2;
  localparam logic [1:0] OP_RELEASE = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_OWN, S_CAP1, S_CAP2} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [TMR_W-1:0] timer;

  // First requesting index at or after ptr, wrapping; MSB flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (r[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  logic [IDX_W:0] pick;
  logic [1:0]     own_op;
  logic           own_vld;
  logic           own_release;

  assign pick        = rr_pick(req, rr_ptr);
  assign own_op      = op[{owner, 1'b0} +: 2];
  assign own_vld     = op_valid[owner];
  assign own_release = (own_vld && (own_op == OP_RELEASE)) || !req[owner];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      timer        <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      cc_enable    <= 1'b0;
      cc_command   <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      result_owner <= '0;
      timeout_err  <= 1'b0;
    end else begin
      cc_enable    <= 1'b0;
      cc_command   <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick[IDX_W]) begin
            owner     <= pick[IDX_W-1:0];
            busy      <= 1'b1;
            cc_enable <= 1'b1;
            state     <= S_CLR;
          end
        end
        S_CLR: begin
          timer <= '0;
          grant <= onehot(owner);
          state <= S_OWN;
        end
        S_OWN: begin
          // Release beats timeout; both end the session with a stop command.
          if (own_release || (timer == TMR_LAST)) begin
            cc_enable   <= 1'b1;
            cc_command  <= 32'(OP_STOP);
            timeout_err <= !own_release;
            grant       <= '0;
            state       <= S_CAP1;
          end else begin
            timer <= timer + TMR_W'(1);
            if (own_vld) begin
              cc_enable  <= 1'b1;
              cc_command <= 32'(own_op);
            end
          end
        end
        S_CAP1: state <= S_CAP2;
        S_CAP2: begin
          result       <= cc_count;
          result_owner <= onehot(owner);
          result_valid <= 1'b1;
          rr_ptr       <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_counter_arbiter.sv
// Bench for clock_counter_arbiter: session-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_clock_counter_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  op_valid = '0;
  logic [2*N-1:0] op = '0;
  logic [N-1:0]  grant;
  logic          busy;
  logic          cc_enable;
  logic [31:0]   cc_command;
  logic [W-1:0]  cc_count;
  logic [W-1:0]  result;
  logic          result_valid;
  logic [N-1:0]  result_owner;
  logic          timeout_err;

  clock_counter_arbiter #(.N_REQ(N), .CNT_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .op_valid(op_valid), .op(op),
    .grant(grant), .busy(busy), .cc_enable(cc_enable), .cc_command(cc_command),
    .cc_count(cc_count), .result(result), .result_valid(result_valid),
    .result_owner(result_owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int rv_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shared counter: samples enable/command on the falling edge.
  logic        run = 1'b0;
  logic [31:0] cnt = '0;
  assign cc_count = cnt;
  initial forever begin
    @(negedge clk);
    if (cc_enable === 1'b1) begin
      case (cc_command)
        32'd0: cnt = '0;
        32'd1: run = 1'b1;
        32'd2: run = 1'b0;
        default: ;
      endcase
    end else if (run) cnt = cnt + 1;
  end

  initial forever begin
    @(posedge clk);
    if (result_valid === 1'b1) rv_cnt++;
  end

  // Reference model: session bookkeeping (owner, own-cycle count, capture countdown).
  int m_own, m_ownc, m_cap, m_ptr;
  logic [N-1:0] e_grant, e_rowner;
  logic         e_busy, e_en, e_rv, e_te;
  logic [31:0]  e_cmd, e_res;

  task automatic m_reset();
    m_own = -1; m_ownc = 0; m_cap = 0; m_ptr = 0;
    e_grant = '0; e_rowner = '0; e_busy = 0; e_en = 0; e_rv = 0; e_te = 0;
    e_cmd = '0; e_res = '0;
  endtask

  task automatic m_step();
    logic [1:0] o;
    bit rel;
    e_en = 0; e_cmd = '0; e_rv = 0; e_te = 0;
    if (m_cap > 0) begin
      m_cap--;
      if (m_cap == 0) begin
        e_res = cc_count; e_rowner = N'(1 << m_own); e_rv = 1;
        m_ptr = (m_own + 1) % N; m_own = -1; e_busy = 0;
      end
    end else if (m_own < 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
      if (m_own >= 0) begin
        m_ownc = -1; e_en = 1; e_cmd = 0; e_busy = 1;
      end
    end else if (m_ownc < 0) begin
      m_ownc = 0; e_grant = N'(1 << m_own);
    end else begin
      o = op[2*m_own +: 2];
      rel = (op_valid[m_own] && o == 2'd3) || !req[m_own];
      m_ownc++;
      if (rel || m_ownc == TO) begin
        e_en = 1; e_cmd = 2; e_te = !rel; e_grant = '0; m_cap = 2;
      end else if (op_valid[m_own]) begin
        e_en = 1; e_cmd = 32'(o);
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("grant", 32'(grant), 32'(e_grant));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cc_enable", 32'(cc_enable), 32'(e_en));
    chk("cc_command", cc_command, e_cmd);
    chk("result_valid", 32'(result_valid), 32'(e_rv));
    chk("result", result, e_res);
    chk("result_owner", 32'(result_owner), 32'(e_rowner));
    chk("timeout_err", 32'(timeout_err), 32'(e_te));
  end

  task automatic send_op(input int idx, input logic [1:0] code);
    op_valid[idx] = 1'b1;
    op[2*idx +: 2] = code;
    @(negedge clk);
    op_valid = '0;
  endtask

  task automatic wait_grant(input logic [N-1:0] m, input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (grant !== m && waited < budget);
    if (grant !== m) begin
      n_checks++; n_err++;
      $display("FAIL wait_grant: got %0h expected %0h within %0d cycles", grant, m, budget);
    end
  endtask

  task automatic wait_any_grant(input int budget, output logic [N-1:0] g);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (grant === '0 && w < budget);
    g = grant;
    if (grant === '0) begin
      n_checks++; n_err++;
      $display("FAIL wait_any_grant: got 0 expected nonzero within %0d cycles", budget);
    end
  endtask

  task automatic wait_rv(input int budget);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (result_valid !== 1'b1 && w < budget);
    if (result_valid !== 1'b1) begin
      n_checks++; n_err++;
      $display("FAIL wait_rv: got 0 expected 1 within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; op_valid = '0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [N-1:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int w, own_cycles, rv0;
    logic [N-1:0] g;

    repeat (3) @(negedge clk);
    chk("reset_grant", 32'(grant), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_result", result, 0);
    reset_n = 1'b1;

    // Single session: clear pulse, grant, ~10 counted cycles.
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    chk("t1_clr_en", 32'(cc_enable), 1);
    chk("t1_clr_cmd", cc_command, 0);
    chk("t1_clr_grant", 32'(grant), 0);
    @(negedge clk);
    chk("t1_grant", 32'(grant), 32'b0001);
    send_op(0, 2'd1);
    repeat (9) @(negedge clk);
    send_op(0, 2'd2);
    send_op(0, 2'd3);
    req = '0;
    wait_rv(10);
    chk("t1_result_range", 32'(result >= 9 && result <= 11), 1);
    chk("t1_result_owner", 32'(result_owner), 32'b0001);

    // Round robin with all requesting.
    do_reset();
    rv_cnt = 0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_any_grant(20, g);
      chk("t2_order", 32'(g), 32'(order[k]));
      if (k == 4) chk("t2_rv_count", rv_cnt, 4);
      for (int i = 0; i < N; i++) if (g[i]) send_op(i, 2'd3);
    end
    req = '0;
    repeat (6) @(negedge clk);

    // Non-owner ops ignored, owner ops forwarded for one cycle.
    do_reset();
    req = 4'b0100;
    wait_grant(4'b0100, 10, w);
    req = 4'b0101;
    send_op(0, 2'd1);
    chk("t3_nonowner_en", 32'(cc_enable), 0);
    send_op(2, 2'd1);
    chk("t3_owner_en", 32'(cc_enable), 1);
    chk("t3_owner_cmd", cc_command, 1);
    @(negedge clk);
    chk("t3_owner_en_drop", 32'(cc_enable), 0);
    send_op(2, 2'd3);
    req = 4'b0001;
    wait_grant(4'b0001, 10, w);
    chk("t3_gap", w, 4);

    // Owner drops req without release.
    req = 4'b0011;
    rv0 = rv_cnt;
    @(negedge clk);
    req = 4'b0010;
    wait_grant(4'b0010, 10, w);
    chk("t5_gap", w, 5);
    chk("t5_rv", rv_cnt - rv0, 1);
    chk("t5_result_owner", 32'(result_owner), 32'b0001);
    req = '0;
    repeat (6) @(negedge clk);

    // Forced release after TO own cycles.
    do_reset();
    req = 4'b0001;
    wait_grant(4'b0001, 10, w);
    own_cycles = 1;
    while (grant === 4'b0001 && own_cycles < 40) begin
      @(negedge clk);
      if (grant === 4'b0001) own_cycles++;
    end
    chk("t4_own_cycles", own_cycles, TO);
    chk("t4_timeout_err", 32'(timeout_err), 1);
    chk("t4_stop_en", 32'(cc_enable), 1);
    chk("t4_stop_cmd", cc_command, 2);
    req = '0;
    @(negedge clk);
    chk("t4_timeout_pulse", 32'(timeout_err), 0);
    wait_rv(5);
    chk("t4_result_owner", 32'(result_owner), 32'b0001);

    // Reset mid-session clears outputs and the round-robin pointer.
    do_reset();
    req = 4'b0001;
    wait_grant(4'b0001, 10, w);
    send_op(0, 2'd3);
    req = '0;
    wait_rv(6);
    req = 4'b0100;
    wait_grant(4'b0100, 10, w);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_result", result, 0);
    chk("t6_result_valid", 32'(result_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b0101;
    wait_any_grant(10, g);
    chk("t6_rr_reset", 32'(g), 32'b0001);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 31) == 0) req[i] = ~req[i];
      op_valid = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      op = 8'($urandom);
    end
    req = '0; op_valid = '0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
